mdu_ctrl: RTL and testbench
===========================

# mdu_ctrl

Multiply/divide unit controller for the 5-stage MIPS core. It sits beside the EX-stage ALU and owns the architectural HI/LO registers. It runs MULT/MULTU/DIV/DIVU as one iterative radix-2 engine shared between multiply and divide, and executes MTHI/MTLO in a single cycle. It stalls the pipeline through `busy` and aborts in-flight work on an exception flush.

## Interface
Parameters:
- none (datapath fixed at 32 bits, 32 iterations)

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- resetn  in  1  asynchronous, active-low reset
- op_valid  in  1  EX stage holds a valid instruction with the flags below
- op_mul  in  1  MULT/MULTU
- op_mul_signed  in  1  MULT (signed); meaningful only with op_mul
- op_div  in  1  DIV/DIVU
- op_div_signed  in  1  DIV (signed); meaningful only with op_div
- op_mthi  in  1  MTHI
- op_mtlo  in  1  MTLO
- src_a  in  32  rs value (multiplicand/dividend; MTHI/MTLO data)
- src_b  in  32  rt value (multiplier/divisor)
- cancel  in  1  exception/ERET flush of the EX instruction
- busy  out  1  pipeline stall request
- done  out  1  multiply/divide result commits at the end of this cycle
- hi  out  32  architectural HI
- lo  out  32  architectural LO

## Operation
- FSM states: IDLE, RUN, FIX. Reset forces IDLE, hi=lo=0, iteration counter=0, internal accumulators=0, busy=0, done=0.
- Flag priority if several are set: op_div > op_mul > op_mthi > op_mtlo.
- Acceptance, IDLE only: op_valid & ~cancel.
  - div/mul: latch operand magnitudes (signed ops take two's-complement absolute value), result-sign and remainder-sign bits, and the op type; go to RUN with count=0.
  - mthi: hi<=src_a. mtlo: lo<=src_a. FSM stays in IDLE.
- op_valid is ignored outside IDLE, because the pipeline is holding the same instruction.
- RUN, multiply: shift-add with a 64-bit accumulator, one multiplier bit per cycle, LSB first.
- RUN, divide: restoring division with a 33-bit partial remainder, one quotient bit per cycle, MSB first.
- RUN: count increments every cycle; after the count=31 iteration go to FIX.
- FIX, multiply: negate the 64-bit product if the result sign is set; {hi,lo}<=product.
- FIX, divide: lo<=quotient, negated if the operand signs differ; hi<=remainder, which takes the dividend's sign.
- FIX then returns to IDLE.
- Signed 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wrap, no trap).
- Divide by zero: full timing, done pulses, hi/lo left unchanged.
- cancel in RUN or FIX: next edge returns to IDLE, hi/lo unchanged, done=0 in that cycle. cancel in IDLE blocks acceptance, so no mthi/mtlo write occurs. cancel has priority over every other event.
- busy = resetn & ((IDLE & op_valid & ~cancel & (op_div|op_mul)) | RUN).
- done = FIX & ~cancel.

## Timing
- T0: div/mul acceptance cycle; busy=1 combinationally, so EX holds.
- T1..T32: RUN (32 cycles), busy=1.
- T33: FIX; busy=0, done=1; EX instruction advances; hi/lo written at the T33 edge.
- T34: new hi/lo visible, FSM in IDLE, next op accepted.
- A div/mul occupies 34 cycles, with 33 stall cycles.
- mthi/mtlo: busy=0; hi/lo update at the acceptance edge and are visible the next cycle. An MFHI/MFLO one cycle later sees the new value without forwarding.
- Asynchronous reset mid-operation: immediate return to IDLE with hi=lo=0 and busy=done=0; the partial result is discarded.
- Back-to-back: a mult in EX the cycle after FIX is accepted with no bubble.

## Test plan
- MULTU 0xFFFFFFFF×0xFFFFFFFF at T0 -> busy high T0..T32, done at T33, hi=0xFFFFFFFE, lo=0x00000001 at T34.
- MULT 0xFFFFFFF9(−7)×0x00000003 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV 0xFFFFFFF9(−7)/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100/7 -> lo=14, hi=2; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI 0x12345678 followed next cycle by MTLO 0x9ABCDEF0 -> busy stays 0; hi then lo update on consecutive edges. DIVU 5/0 with prior hi/lo -> done at T33, hi/lo unchanged.
- DIV 100/7 with cancel at T10 -> IDLE at T11, done never pulses, hi/lo hold prior values; a MULTU 3×4 accepted at T11 -> lo=12 at T45.
- resetn low at T15 of a MULT -> busy=0 and hi=lo=0 immediately; after release, MTLO 5 -> lo=5.

Source files
------------

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - iterative radix-2 multiply/divide controller owning HI/LO
module mdu_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  input  logic        op_mul,
  input  logic        op_mul_signed,
  input  logic        op_div,
  input  logic        op_div_signed,
  input  logic        op_mthi,
  input  logic        op_mtlo,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [4:0]  r_count;
  logic        r_is_div;
  logic        r_res_neg;
  logic        r_rem_neg;
  // Multiplicand for multiply; dividend shifting out / quotient shifting in for divide.
  logic [31:0] r_a;
  // Multiplier (shifted right each step) for multiply; divisor for divide.
  logic [31:0] r_b;
  logic [63:0] r_acc;
  // Only the low 32 bits of the partial remainder are kept between steps: after a
  // restoring step the remainder is always below the divisor.
  logic [31:0] r_rem;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  // Decoded acceptance, with div > mul > mthi > mtlo priority.
  logic        w_accept;
  logic        w_start_div;
  logic        w_start_mul;
  logic        w_start;
  logic        w_wr_mthi;
  logic        w_wr_mtlo;
  logic        w_signed;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;

  // Iteration datapath.
  logic [32:0] w_mul_sum;
  logic [63:0] w_acc_next;
  logic [32:0] w_div_shift;
  logic [32:0] w_div_diff;
  logic        w_q_bit;
  logic [31:0] w_rem_next;

  // Sign fix-up applied in FIX.
  logic [63:0] w_prod_fix;
  logic [31:0] w_quo_fix;
  logic [31:0] w_rem_fix;
  logic        w_commit;

  assign w_accept    = (r_state == IDLE) & op_valid & ~cancel;
  assign w_start_div = w_accept & op_div;
  assign w_start_mul = w_accept & ~op_div & op_mul;
  assign w_start     = w_start_div | w_start_mul;
  assign w_wr_mthi   = w_accept & ~op_div & ~op_mul & op_mthi;
  assign w_wr_mtlo   = w_accept & ~op_div & ~op_mul & ~op_mthi & op_mtlo;

  assign w_signed = op_div ? op_div_signed : op_mul_signed;
  assign w_a_neg  = w_signed & src_a[31];
  assign w_b_neg  = w_signed & src_b[31];
  assign w_a_mag  = w_a_neg ? (32'd0 - src_a) : src_a;
  assign w_b_mag  = w_b_neg ? (32'd0 - src_b) : src_b;

  // Shift-add: add the multiplicand into the upper half when the current multiplier
  // bit is set, then shift the whole accumulator right by one.
  assign w_mul_sum  = {1'b0, r_acc[63:32]} + {1'b0, (r_b[0] ? r_a : 32'd0)};
  assign w_acc_next = {w_mul_sum, r_acc[31:1]};

  // Restoring division: bring in the next dividend bit, trial-subtract the divisor,
  // keep the difference only if it did not go negative.
  assign w_div_shift = {r_rem, r_a[31]};
  assign w_div_diff  = w_div_shift - {1'b0, r_b};
  assign w_q_bit     = ~w_div_diff[32];
  assign w_rem_next  = w_q_bit ? w_div_diff[31:0] : w_div_shift[31:0];

  assign w_prod_fix = r_res_neg ? (64'd0 - r_acc) : r_acc;
  assign w_quo_fix  = r_res_neg ? (32'd0 - r_a) : r_a;
  assign w_rem_fix  = r_rem_neg ? (32'd0 - r_rem) : r_rem;
  assign w_commit   = (r_state == FIX) & ~cancel;

  assign busy = resetn & ((w_start) | (r_state == RUN));
  assign done = w_commit;
  assign hi   = r_hi;
  assign lo   = r_lo;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; cancel overrides everything while an operation is in flight.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_next = RUN;
        end
      end
      RUN: begin
        if (cancel) begin
          w_next = IDLE;
        end else if (r_count == 5'd31) begin
          w_next = FIX;
        end
      end
      FIX: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Operand capture on acceptance and one radix-2 step per RUN cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count   <= 5'd0;
      r_is_div  <= 1'b0;
      r_res_neg <= 1'b0;
      r_rem_neg <= 1'b0;
      r_a       <= 32'd0;
      r_b       <= 32'd0;
      r_acc     <= 64'd0;
      r_rem     <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_count   <= 5'd0;
            r_is_div  <= w_start_div;
            r_res_neg <= w_a_neg ^ w_b_neg;
            r_rem_neg <= w_a_neg;
            r_a       <= w_a_mag;
            r_b       <= w_b_mag;
            r_acc     <= 64'd0;
            r_rem     <= 32'd0;
          end
        end
        RUN: begin
          r_count <= r_count + 5'd1;
          if (r_is_div) begin
            r_rem <= w_rem_next;
            r_a   <= {r_a[30:0], w_q_bit};
          end else begin
            r_acc <= w_acc_next;
            r_b   <= {1'b0, r_b[31:1]};
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Architectural HI/LO: written by MTHI/MTLO on acceptance or by a committing FIX.
  // A divide by zero commits nothing, leaving HI/LO untouched.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else if (w_commit) begin
      if (!r_is_div) begin
        r_hi <= w_prod_fix[63:32];
        r_lo <= w_prod_fix[31:0];
      end else if (r_b != 32'd0) begin
        r_hi <= w_rem_fix;
        r_lo <= w_quo_fix;
      end
    end else if (w_wr_mthi) begin
      r_hi <= src_a;
    end else if (w_wr_mtlo) begin
      r_lo <= src_a;
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - directed and random checks of mdu_ctrl against an arithmetic model
module tb_mdu_ctrl;

  logic        clk;
  logic        resetn;
  logic        op_valid;
  logic        op_mul;
  logic        op_mul_signed;
  logic        op_div;
  logic        op_div_signed;
  logic        op_mthi;
  logic        op_mtlo;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mdu_ctrl dut (
    .clk           (clk),
    .resetn        (resetn),
    .op_valid      (op_valid),
    .op_mul        (op_mul),
    .op_mul_signed (op_mul_signed),
    .op_div        (op_div),
    .op_div_signed (op_div_signed),
    .op_mthi       (op_mthi),
    .op_mtlo       (op_mtlo),
    .src_a         (src_a),
    .src_b         (src_b),
    .cancel        (cancel),
    .busy          (busy),
    .done          (done),
    .hi            (hi),
    .lo            (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_ops();
    op_valid = 1'b0; op_mul = 1'b0; op_mul_signed = 1'b0; op_div = 1'b0;
    op_div_signed = 1'b0; op_mthi = 1'b0; op_mtlo = 1'b0; cancel = 1'b0;
  endtask

  // Reference: full-width arithmetic; SV division truncates toward zero and the
  // remainder follows the dividend, exactly the MIPS rules.
  task automatic model(input bit is_div, input bit sgn, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] nh,
                       output logic [31:0] nl, output bit wr);
    longint      sa, sb, q, r;
    logic [63:0] p;
    wr = 1'b1;
    nh = m_hi;
    nl = m_lo;
    sa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
    sb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
    if (!is_div) begin
      p  = sa * sb;
      nh = p[63:32];
      nl = p[31:0];
    end else if (b == 32'd0) begin
      wr = 1'b0;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      nl = q[31:0];
      nh = r[31:0];
    end
  endtask

  // One mul/div from T0 through T33 (or until cancel/reset at the given cycle).
  task automatic run_op(input bit is_div, input bit sgn, input logic [31:0] a,
                        input logic [31:0] b, input int cancel_at, input int reset_at);
    logic [31:0] nh, nl;
    bit          wr;
    model(is_div, sgn, a, b, nh, nl, wr);
    @(negedge clk);
    clear_ops();
    op_valid = 1'b1; op_div = is_div; op_mul = ~is_div;
    op_div_signed = sgn; op_mul_signed = sgn; src_a = a; src_b = b;
    #1;
    chk("T0 busy", busy, 1); chk("T0 done", done, 0);
    chk("T0 hi", hi, m_hi); chk("T0 lo", lo, m_lo);
    for (int t = 1; t <= 33; t++) begin
      @(negedge clk);
      src_a = $urandom; src_b = $urandom;
      if (t == cancel_at) cancel = 1'b1;
      if (t == reset_at) resetn = 1'b0;
      #1;
      if (t == reset_at) begin
        m_hi = 32'd0; m_lo = 32'd0;
        chk("rst busy", busy, 0); chk("rst done", done, 0);
        chk("rst hi", hi, 0); chk("rst lo", lo, 0);
        @(negedge clk);
        resetn = 1'b1;
        clear_ops();
        return;
      end
      chk($sformatf("T%0d busy", t), busy, (t <= 32));
      chk($sformatf("T%0d done", t), done, (t == 33 && t != cancel_at));
      chk($sformatf("T%0d hi", t), hi, m_hi);
      chk($sformatf("T%0d lo", t), lo, m_lo);
      if (t == cancel_at) return;
    end
    if (wr) begin
      m_hi = nh;
      m_lo = nl;
    end
  endtask

  task automatic mt(input bit to_hi, input bit to_lo, input logic [31:0] d, input bit canc);
    @(negedge clk);
    clear_ops();
    op_valid = 1'b1; op_mthi = to_hi; op_mtlo = to_lo; src_a = d; cancel = canc;
    #1;
    chk("mt busy", busy, 0); chk("mt done", done, 0);
    chk("mt hi", hi, m_hi); chk("mt lo", lo, m_lo);
    if (!canc) begin
      if (to_hi) m_hi = d;
      else if (to_lo) m_lo = d;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    clear_ops();
    #1;
    chk("idle busy", busy, 0); chk("idle done", done, 0);
    chk("idle hi", hi, m_hi); chk("idle lo", lo, m_lo);
  endtask

  initial begin
    logic [31:0] ra, rb;
    bit          rdiv, rsgn;
    clear_ops();
    src_a = 32'd0; src_b = 32'd0;
    resetn = 1'b0;
    #1;
    chk("reset busy", busy, 0); chk("reset done", done, 0);
    chk("reset hi", hi, 0); chk("reset lo", lo, 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    idle();

    run_op(1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, -1);
    idle();
    chk("multu max hi", hi, 32'hFFFFFFFE); chk("multu max lo", lo, 32'h00000001);

    run_op(1'b0, 1'b1, 32'hFFFFFFF9, 32'h00000003, -1, -1);
    run_op(1'b1, 1'b1, 32'hFFFFFFF9, 32'h00000002, -1, -1);
    run_op(1'b1, 1'b0, 32'd100, 32'd7, -1, -1);
    run_op(1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, -1, -1);
    idle();
    chk("div ovf hi", hi, 32'h0); chk("div ovf lo", lo, 32'h80000000);

    mt(1'b1, 1'b0, 32'h12345678, 1'b0);
    mt(1'b0, 1'b1, 32'h9ABCDEF0, 1'b0);
    idle();
    chk("mthi value", hi, 32'h12345678); chk("mtlo value", lo, 32'h9ABCDEF0);

    run_op(1'b1, 1'b0, 32'd5, 32'd0, -1, -1);
    idle();

    run_op(1'b1, 1'b1, 32'd100, 32'd7, 10, -1);
    run_op(1'b0, 1'b0, 32'd3, 32'd4, -1, -1);
    idle();
    chk("multu 3x4 lo", lo, 32'd12);

    run_op(1'b0, 1'b0, 32'h0000FFFF, 32'h00010001, 33, -1);
    idle();

    mt(1'b1, 1'b1, 32'hCAFEF00D, 1'b0);
    mt(1'b1, 1'b0, 32'hDEADBEEF, 1'b1);
    mt(1'b0, 1'b1, 32'h0BADC0DE, 1'b1);
    idle();

    for (int i = 0; i < 12; i++) begin
      rdiv = 1'($urandom_range(0, 1));
      rsgn = 1'($urandom_range(0, 1));
      ra   = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 15);
        2:       rb = 32'd0 - 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      run_op(rdiv, rsgn, ra, rb, -1, -1);
    end
    idle();

    run_op(1'b0, 1'b1, 32'h00001234, 32'h00005678, -1, 15);
    idle();
    mt(1'b0, 1'b1, 32'd5, 1'b0);
    idle();
    chk("post-reset mtlo", lo, 32'd5);
    chk("post-reset hi", hi, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
